// File: rtl/fuzz_stim_pkg.sv
// Shared types and constants for the fuzz stimulus generator: FSM states,
// LFSR taps, stimulus bus slice bounds and the zero-seed substitute.
package fuzz_stim_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_e;

   // Taps at bits 63, 62, 60 and 59 of the left-shifting Fibonacci LFSR
   localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

   localparam int W0_LO = 0;
   localparam int W0_HI = 10;
   localparam int W1_LO = 11;
   localparam int W1_HI = 23;
   localparam int W2_LO = 24;
   localparam int W2_HI = 43;
   localparam int W3_LO = 44;
   localparam int W3_HI = 63;

   localparam logic [63:0] ZERO_SEED_SUB = 64'h0000_0000_0000_0001;

   function automatic logic [63:0] seed_guard(input logic [63:0] s);
      return (s == '0) ? ZERO_SEED_SUB : s;
   endfunction

   function automatic logic [63:0] lfsr_next(input logic [63:0] s);
      return {s[62:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/fuzz_lfsr64.sv
// 64-bit seeded Fibonacci LFSR. A load combined with an advance loads the
// seed and steps it once in the same edge; zero seeds are replaced by 1.
module fuzz_lfsr64 import fuzz_stim_pkg::*; #(
   parameter logic [63:0] SEED = 64'h0000_0000_0000_0001
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic [63:0] seed_i,
   input  logic        advance_i,
   output logic [63:0] state_o
);

   logic [63:0] state_q;
   logic [63:0] loaded;

   assign loaded  = seed_guard(seed_i);
   assign state_o = state_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= seed_guard(SEED);
      end else if (load_i) begin
         state_q <= advance_i ? lfsr_next(loaded) : loaded;
      end else if (advance_i) begin
         state_q <= lfsr_next(state_q);
      end
   end

endmodule

// File: rtl/fuzz_stim_gen.sv
// Reproducible stimulus source: start/busy/done handshake, vector counter and
// registered wire buses. Optional macro FUZZ_STIM_CORNER_EN prepends zero/one vectors.
module fuzz_stim_gen import fuzz_stim_pkg::*; #(
   parameter logic [63:0] SEED  = 64'h0000_0000_0000_0001,
   parameter int          CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             seed_load,
   input  logic [63:0]      seed,
   input  logic [CNT_W-1:0] num_vec,
   output logic             busy,
   output logic             done,
   output logic             vec_valid,
   output logic [CNT_W-1:0] vec_idx,
   output logic [10:0]      wire0,
   output logic [12:0]      wire1,
   output logic [19:0]      wire2,
   output logic [19:0]      wire3
);

`ifdef FUZZ_STIM_CORNER_EN
   localparam bit CORNER_EN = 1'b1;
`else
   localparam bit CORNER_EN = 1'b0;
`endif

   state_e           state_q;
   logic [CNT_W-1:0] numVec_q;
   logic [CNT_W-1:0] vecIdx_q;
   logic             busy_q;
   logic             done_q;
   logic             valid_q;
   logic [10:0]      wire0_q;
   logic [12:0]      wire1_q;
   logic [19:0]      wire2_q;
   logic [19:0]      wire3_q;

   logic [63:0]      lfsrState;
   logic [63:0]      lfsrBase;
   logic             lfsrLoad;
   logic             idleGo;
   logic             isLast;
   logic             advance;
   logic [CNT_W-1:0] emitIdx;
   logic [63:0]      vec_d;

   // The vector registered on an edge is the LFSR's next value, taken from
   // the freshly loaded seed when seed_load coincides with start.
   always_comb begin
      lfsrLoad = (state_q == ST_IDLE) && seed_load;
      lfsrBase = lfsrLoad ? seed_guard(seed) : lfsrState;
      idleGo   = (state_q == ST_IDLE) && start && (num_vec != '0);
      isLast   = (vecIdx_q == numVec_q - CNT_W'(1));
      emitIdx  = idleGo ? '0 : vecIdx_q + CNT_W'(1);
      vec_d    = lfsr_next(lfsrBase);
      advance  = idleGo || ((state_q == ST_RUN) && !isLast);
      if (CORNER_EN && (emitIdx < CNT_W'(2))) begin
         vec_d   = (emitIdx == '0) ? '0 : '1;
         advance = 1'b0;
      end
   end

   fuzz_lfsr64 #(.SEED(SEED)) u_lfsr (
      .clk       (clk),
      .rst       (rst),
      .load_i    (lfsrLoad),
      .seed_i    (seed),
      .advance_i (advance),
      .state_o   (lfsrState)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         numVec_q <= '0;
         vecIdx_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         valid_q  <= 1'b0;
         wire0_q  <= '0;
         wire1_q  <= '0;
         wire2_q  <= '0;
         wire3_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  numVec_q <= num_vec;
                  if (num_vec != '0) begin
                     state_q  <= ST_RUN;
                     busy_q   <= 1'b1;
                     valid_q  <= 1'b1;
                     vecIdx_q <= '0;
                     wire0_q  <= vec_d[W0_HI:W0_LO];
                     wire1_q  <= vec_d[W1_HI:W1_LO];
                     wire2_q  <= vec_d[W2_HI:W2_LO];
                     wire3_q  <= vec_d[W3_HI:W3_LO];
                  end else begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (isLast) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  valid_q <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  vecIdx_q <= emitIdx;
                  wire0_q  <= vec_d[W0_HI:W0_LO];
                  wire1_q  <= vec_d[W1_HI:W1_LO];
                  wire2_q  <= vec_d[W2_HI:W2_LO];
                  wire3_q  <= vec_d[W3_HI:W3_LO];
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign vec_valid = valid_q;
   assign vec_idx   = vecIdx_q;
   assign wire0     = wire0_q;
   assign wire1     = wire1_q;
   assign wire2     = wire2_q;
   assign wire3     = wire3_q;

endmodule

// File: tb/tb_fuzz_stim_gen.sv
// Randomized bench for fuzz_stim_gen against a cycle-level reference model
// that tracks the LFSR sequence and the expected handshake timing.
module tb_fuzz_stim_gen;

`ifdef FUZZ_STIM_CORNER_EN
   localparam bit CORNER = 1'b1;
`else
   localparam bit CORNER = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        seed_load;
   logic [63:0] seed;
   logic [15:0] num_vec;
   logic        busy;
   logic        done;
   logic        vec_valid;
   logic [15:0] vec_idx;
   logic [10:0] wire0;
   logic [12:0] wire1;
   logic [19:0] wire2;
   logic [19:0] wire3;

   int          totalChecks = 0;
   int          badChecks = 0;
   logic [63:0] mState;
   logic [63:0] mLast;
   logic [63:0] obsVec;

   always #5 clk = ~clk;

   assign obsVec = {wire3, wire2, wire1, wire0};

   fuzz_stim_gen #(.SEED(64'h0000_0000_0000_0001), .CNT_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .seed_load (seed_load),
      .seed      (seed),
      .num_vec   (num_vec),
      .busy      (busy),
      .done      (done),
      .vec_valid (vec_valid),
      .vec_idx   (vec_idx),
      .wire0     (wire0),
      .wire1     (wire1),
      .wire2     (wire2),
      .wire3     (wire3)
   );

   function automatic logic [63:0] refStep(input logic [63:0] s);
      logic fb;
      fb = s[63] ^ s[62] ^ s[60] ^ s[59];
      return (s << 1) | {63'd0, fb};
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      totalChecks++;
      if (got !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic loadOnly(input logic [63:0] s);
      start     = 1'b0;
      seed_load = 1'b1;
      seed      = s;
      mState    = (s == 64'd0) ? 64'd1 : s;
      @(negedge clk);
      seed_load = 1'b0;
      checkOutput("loadFlags", {61'd0, busy, vec_valid, done}, 64'd0);
      checkOutput("loadHold", obsVec, mLast);
   endtask

   // One run starting at this negedge; abortAfter>0 pulses rst after that many vectors.
   task automatic applyStimulus(input int num, input bit doLoad, input logic [63:0] loadSeed,
                                input int abortAfter);
      logic [63:0] exp;
      start     = 1'b1;
      num_vec   = num[15:0];
      seed_load = doLoad;
      seed      = loadSeed;
      if (doLoad) mState = (loadSeed == 64'd0) ? 64'd1 : loadSeed;
      @(negedge clk);
      for (int i = 0; i < num; i++) begin
         start     = 1'($urandom % 2);
         seed_load = 1'($urandom % 2);
         seed      = {$urandom, $urandom};
         if (CORNER && i < 2) begin
            exp = (i == 0) ? 64'd0 : {64{1'b1}};
         end else begin
            mState = refStep(mState);
            exp    = mState;
         end
         mLast = exp;
         checkOutput($sformatf("vec%0d", i), obsVec, exp);
         checkOutput($sformatf("runFlags%0d", i), {61'd0, busy, vec_valid, done}, 64'b110);
         checkOutput($sformatf("idx%0d", i), 64'(vec_idx), 64'(i));
         if (i + 1 == abortAfter) begin
            rst       = 1'b1;
            start     = 1'b0;
            seed_load = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            checkOutput("abortFlags", {61'd0, busy, vec_valid, done}, 64'd0);
            checkOutput("abortVec", obsVec, 64'd0);
            checkOutput("abortIdx", 64'(vec_idx), 64'd0);
            mState = 64'd1;
            mLast  = 64'd0;
            return;
         end
         @(negedge clk);
      end
      checkOutput("doneFlags", {61'd0, busy, vec_valid, done}, 64'b001);
      checkOutput("doneHold", obsVec, mLast);
      start     = 1'($urandom % 2);
      seed_load = 1'($urandom % 2);
      seed      = {$urandom, $urandom};
      @(negedge clk);
      start     = 1'b0;
      seed_load = 1'b0;
      checkOutput("idleFlags", {61'd0, busy, vec_valid, done}, 64'd0);
      checkOutput("idleHold", obsVec, mLast);
   endtask

   initial begin
      logic [63:0] s;
      rst       = 1'b1;
      start     = 1'b0;
      seed_load = 1'b0;
      seed      = 64'd0;
      num_vec   = 16'd0;
      repeat (2) @(negedge clk);
      checkOutput("rstFlags", {61'd0, busy, vec_valid, done}, 64'd0);
      checkOutput("rstVec", obsVec, 64'd0);
      checkOutput("rstIdx", 64'(vec_idx), 64'd0);
      rst    = 1'b0;
      mState = 64'd1;
      mLast  = 64'd0;

      applyStimulus(4, 1'b0, 64'd0, 0);
      applyStimulus(3, 1'b0, 64'd0, 0);
      applyStimulus(1, 1'b1, {64{1'b1}}, 0);
      applyStimulus(1, 1'b1, 64'd0, 0);
      applyStimulus(0, 1'b0, 64'd0, 0);
      loadOnly(64'h1234_5678_9ABC_DEF0);
      applyStimulus(4, 1'b0, 64'd0, 0);

      s = 64'hCAFE_F00D_0BAD_BEEF;
      applyStimulus(10, 1'b1, s, 5);
      applyStimulus(5, 1'b1, s, 0);

      for (int k = 0; k < 8; k++) begin
         applyStimulus($urandom_range(0, 12), 1'($urandom % 2), {$urandom, $urandom}, 0);
      end

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
